pam_searcher_axil_regs: RTL and testbench
=========================================

Name: pam_searcher_axil_regs

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the PamSearcher S00_AXI 4-register slave.
- Sits between the AXI interconnect and the PAM search core.
- Provides NUM_CTRL read/write control registers and NUM_STAT read-only status registers.
- Adds byte strobes, independent AW/W acceptance, per-register write pulses and SLVERR decoding.

Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- ADDR_WIDTH, 6, AXI address width; must cover (NUM_CTRL+NUM_STAT)*DATA_WIDTH/8 bytes.
- NUM_CTRL, 4, number of RW control registers at word indices 0..NUM_CTRL-1.
- NUM_STAT, 2, number of RO status registers at word indices NUM_CTRL..NUM_CTRL+NUM_STAT-1.
- CTRL_RESET, 0, reset value of every control register.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
- ctrl_q  out  NUM_CTRL*DATA_WIDTH  flat control register contents; register k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- ctrl_wr_pulse  out  NUM_CTRL  one-cycle strobe when register k is written
- stat_d  in  NUM_STAT*DATA_WIDTH  status values, sampled when read

Behaviour:
- Reset (async assert, sync release):
  - all READY/VALID outputs are 0;
  - BRESP, RRESP, RDATA are 0;
  - ctrl_q = CTRL_RESET; ctrl_wr_pulse = 0.
- Reset mid-transaction drops all pending AW/W/B/R state. No response is owed afterwards.
- Word index = ADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. Low address bits are ignored.
- Write path states: IDLE, HAVE_AW, HAVE_W, RESP.
  - AWREADY=1 when no AW is held and not in RESP. WREADY=1 when no W is held and not in RESP.
  - AW and W may arrive in either order or in the same cycle.
  - The write commits in the cycle after both are held. BVALID rises in that same cycle; state goes to RESP.
  - Latency is 1 cycle from the last of the AW/W handshakes to BVALID.
  - RESP holds until BVALID&&BREADY, then returns to IDLE. Back-to-back writes are accepted one cycle after B completes.
- Write commit rules:
  - Index < NUM_CTRL: bytes with WSTRB=1 are updated. ctrl_wr_pulse[idx]=1 for exactly one cycle, even when WSTRB=0. BRESP=OKAY(2'b00).
  - Index in the status range, or beyond it: no state change, no pulse, BRESP=SLVERR(2'b10).
- Read path:
  - ARREADY=1 when RVALID=0.
  - On AR handshake, RDATA/RRESP/RVALID are registered in the next edge (1-cycle latency).
  - Control index: RDATA = ctrl_q slice, RRESP=OKAY.
  - Status index: RDATA = stat_d slice sampled on that edge, RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - RVALID holds, with RDATA stable, until RREADY.
- Read and write paths are independent. If a read is accepted in the same cycle a write commits to the same register, the read returns the pre-write value.
- VALID outputs never depend combinationally on READY inputs.

Optional Feature:
- Macro: PAM_SEARCHER_IRQ_EN.
- When defined:
  - adds input irq_set [NUM_STAT] and output irq (1 bit);
  - adds a W1C interrupt register at index NUM_CTRL+NUM_STAT, extending the decode range by one.
  - irq_set[i] sets bit i.
  - A write with WSTRB covering bit i and WDATA[i]=1 clears bit i. Set wins over a same-cycle clear.
  - irq = OR of the bits, registered. Reset value 0.
- When undefined: no extra ports; that index returns SLVERR.

Decomposition:
- Package pam_searcher_axil_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - write-state enum typedef;
  - function word_index(addr);
  - function apply_wstrb(old, data, strb).
- Natural sub-module: pam_searcher_axil_wr_fsm, covering AW/W capture, the state machine and the B channel. The read path and register array stay in the top module.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> each returns its value, OKAY; ctrl_wr_pulse fires once per write.
- W presented 3 cycles before AW to 0x4 with data 0xAABBCCDD, WSTRB=4'b0101, prior value 0x11223344 -> reg1=0x11BB33DD; BVALID 1 cycle after AW handshake.
- Write 0xFFFFFFFF to 0x10 (status), and read 0x3C -> BRESP=SLVERR, ctrl_q unchanged; RRESP=SLVERR, RDATA=0.
- stat_d slice 0 = 0xCAFEF00D, read 0x10 with RREADY held low 5 cycles -> RVALID and RDATA stable the whole time, RRESP=OKAY.
- Assert S_AXI_ARESETN low while BVALID=1 and RVALID=1 -> both drop immediately; ctrl_q returns to CTRL_RESET; next write completes normally.
- PAM_SEARCHER_IRQ_EN: pulse irq_set[0], then write 0x1 to 0x18 in the same cycle as a second irq_set[0] -> irq stays 1; a later clear -> irq=0 one cycle after.

Source files
------------

// File: rtl/pam_searcher_axil_pkg.sv
// Shared definitions for the PAM searcher AXI4-Lite register slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_e              : write-path state encoding
//   word_index()            : byte address -> register word index
//   apply_wstrb()           : byte-enable merge of write data into a register
// The helpers work on the widest supported bus (64-bit data, 32-bit address);
// callers zero-extend their operands and truncate the result.
package pam_searcher_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_HAVE_AW = 2'd1,
      WR_HAVE_W  = 2'd2,
      WR_RESP    = 2'd3
   } wr_state_e;

   function automatic int unsigned word_index(input logic [31:0] addr,
                                              input int unsigned addr_lsb);
      return addr >> addr_lsb;
   endfunction

   function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                               input logic [63:0] data,
                                               input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pam_searcher_axil_wr_fsm.sv
// Write-channel front end: captures AW and W independently, sequences the
// write, and owns the B channel.
//   clk, rst_n     : clock, async active-low reset
//   accept_en      : 0 holds AWREADY/WREADY low (first cycle after reset)
//   aw*/w*/b*      : AXI4-Lite write channels
//   wr_commit      : one-cycle strobe, the write takes effect on this edge
//   wr_addr/data/strb : effective write operands while wr_commit is high
//   wr_resp        : decode result from the register file for wr_addr
//
// state      | meaning
// WR_IDLE    | nothing held, AW and W both accepted
// WR_HAVE_AW | address held, waiting for data
// WR_HAVE_W  | data held, waiting for address
// WR_RESP    | write done, BVALID high until BREADY
module pam_searcher_axil_wr_fsm
   import pam_searcher_axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    accept_en,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   output logic                    wr_commit,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic [1:0]              wr_resp
);

   wr_state_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
   logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
   logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    aw_hs, w_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WR_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bresp_q   <= bresp_d;
      end
   end

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // The commit uses whichever half arrives this cycle straight off the bus,
   // so BVALID follows the last handshake by exactly one cycle.
   assign wr_addr = (state_q == WR_HAVE_AW) ? aw_addr_q : awaddr;
   assign wr_data = (state_q == WR_HAVE_W)  ? w_data_q  : wdata;
   assign wr_strb = (state_q == WR_HAVE_W)  ? w_strb_q  : wstrb;

   always_comb begin
      state_d   = state_q;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bresp_d   = bresp_q;
      wr_commit = 1'b0;
      unique case (state_q)
         WR_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_commit = 1'b1;
               state_d   = WR_RESP;
            end else if (aw_hs) begin
               state_d = WR_HAVE_AW;
            end else if (w_hs) begin
               state_d = WR_HAVE_W;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs) begin
               wr_commit = 1'b1;
               state_d   = WR_RESP;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs) begin
               wr_commit = 1'b1;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bready) state_d = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
      if (aw_hs) aw_addr_d = awaddr;
      if (w_hs) begin
         w_data_d = wdata;
         w_strb_d = wstrb;
      end
      if (wr_commit) bresp_d = wr_resp;
   end

   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      unique case (state_q)
         WR_IDLE: begin
            awready = accept_en;
            wready  = accept_en;
         end
         WR_HAVE_AW: wready  = accept_en;
         WR_HAVE_W:  awready = accept_en;
         WR_RESP:    bvalid  = 1'b1;
         default: ;
      endcase
   end

   assign bresp = bresp_q;

endmodule

// File: rtl/pam_searcher_axil_regs.sv
// AXI4-Lite register slave for the PAM search core.
//   S_AXI_*       : AXI4-Lite slave (AWPROT/ARPROT ignored)
//   ctrl_q        : NUM_CTRL read/write control registers, flattened
//   ctrl_wr_pulse : one-cycle strobe per control register on each write to it
//   stat_d        : NUM_STAT read-only status words, sampled on read accept
// Optional build macro PAM_SEARCHER_IRQ_EN adds irq_set/irq and a W1C
// interrupt register at word index NUM_CTRL+NUM_STAT.
// Map: words 0..NUM_CTRL-1 control, then NUM_STAT status words; anything
// else answers SLVERR (writes to status words also answer SLVERR).
module pam_searcher_axil_regs
   import pam_searcher_axil_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 6,
   parameter int                  NUM_CTRL   = 4,
   parameter int                  NUM_STAT   = 2,
   parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESETN,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q,
   output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
   input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_d
`ifdef PAM_SEARCHER_IRQ_EN
   ,
   input  logic [NUM_STAT-1:0]            irq_set,
   output logic                           irq
`endif
);

   localparam int          STRB_W   = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned IRQ_IDX  = NUM_CTRL + NUM_STAT;

   logic                          accept_en_q;
   logic                          wr_commit;
   logic [ADDR_WIDTH-1:0]         wr_addr;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic [STRB_W-1:0]             wr_strb;
   logic [1:0]                    wr_resp;
   int unsigned                   wr_idx, ar_idx;
   logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_d;
   logic [NUM_CTRL-1:0]           ctrl_wr_pulse_q, ctrl_wr_pulse_d;
   logic                          rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]         rdata_q, rdata_d;
   logic [1:0]                    rresp_q, rresp_d;
   logic                          ar_hs;
   logic                          unused_prot;

   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   pam_searcher_axil_wr_fsm #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_fsm (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .accept_en (accept_en_q),
      .awaddr    (S_AXI_AWADDR),
      .awvalid   (S_AXI_AWVALID),
      .awready   (S_AXI_AWREADY),
      .wdata     (S_AXI_WDATA),
      .wstrb     (S_AXI_WSTRB),
      .wvalid    (S_AXI_WVALID),
      .wready    (S_AXI_WREADY),
      .bresp     (S_AXI_BRESP),
      .bvalid    (S_AXI_BVALID),
      .bready    (S_AXI_BREADY),
      .wr_commit (wr_commit),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_strb   (wr_strb),
      .wr_resp   (wr_resp)
   );

   assign wr_idx = word_index(32'(wr_addr), ADDR_LSB);
   assign ar_idx = word_index(32'(S_AXI_ARADDR), ADDR_LSB);

   // Keeps every READY low while reset is held and for the first cycle after.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) accept_en_q <= 1'b0;
      else                accept_en_q <= 1'b1;
   end

   always_comb begin
      wr_resp = RESP_SLVERR;
      if (wr_idx < NUM_CTRL) wr_resp = RESP_OKAY;
`ifdef PAM_SEARCHER_IRQ_EN
      if (wr_idx == IRQ_IDX) wr_resp = RESP_OKAY;
`endif
   end

   // Control registers; the pulse fires even with an all-zero strobe.
   always_comb begin
      ctrl_d          = ctrl_q;
      ctrl_wr_pulse_d = '0;
      for (int unsigned k = 0; k < NUM_CTRL; k++) begin
         if (wr_commit && wr_idx == k) begin
            ctrl_d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(apply_wstrb(
               64'(ctrl_q[k*DATA_WIDTH +: DATA_WIDTH]), 64'(wr_data), 8'(wr_strb)));
            ctrl_wr_pulse_d[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ctrl_q          <= {NUM_CTRL{CTRL_RESET}};
         ctrl_wr_pulse_q <= '0;
      end else begin
         ctrl_q          <= ctrl_d;
         ctrl_wr_pulse_q <= ctrl_wr_pulse_d;
      end
   end

   assign ctrl_wr_pulse = ctrl_wr_pulse_q;

`ifdef PAM_SEARCHER_IRQ_EN
   logic [NUM_STAT-1:0] irq_bits_q, irq_bits_d, irq_clr;
   logic                irq_q;

   // A same-cycle set overrides the W1C clear.
   always_comb begin
      irq_clr = '0;
      if (wr_commit && wr_idx == IRQ_IDX) begin
         for (int unsigned i = 0; i < NUM_STAT; i++) begin
            irq_clr[i] = wr_strb[i/8] && wr_data[i];
         end
      end
      irq_bits_d = (irq_bits_q & ~irq_clr) | irq_set;
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         irq_bits_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_bits_q <= irq_bits_d;
         irq_q      <= |irq_bits_d;
      end
   end

   assign irq = irq_q;
`endif

   // Read path: ctrl_q is sampled before any same-edge write lands.
   assign S_AXI_ARREADY = accept_en_q && !rvalid_q;
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_SLVERR;
         for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (ar_idx == k) begin
               rdata_d = ctrl_q[k*DATA_WIDTH +: DATA_WIDTH];
               rresp_d = RESP_OKAY;
            end
         end
         for (int unsigned s = 0; s < NUM_STAT; s++) begin
            if (ar_idx == NUM_CTRL + s) begin
               rdata_d = stat_d[s*DATA_WIDTH +: DATA_WIDTH];
               rresp_d = RESP_OKAY;
            end
         end
`ifdef PAM_SEARCHER_IRQ_EN
         if (ar_idx == IRQ_IDX) begin
            rdata_d[NUM_STAT-1:0] = irq_bits_q;
            rresp_d               = RESP_OKAY;
         end
`endif
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_pam_searcher_axil_regs.sv
module tb_pam_searcher_axil_regs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [5:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [127:0] ctrl_q;
   logic [3:0]  ctrl_wr_pulse;
   logic [63:0] stat_d = {32'h5A5A0001, 32'hCAFEF00D};
`ifdef PAM_SEARCHER_IRQ_EN
   logic [1:0]  irq_set = '0;
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pam_searcher_axil_regs dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .ctrl_q        (ctrl_q),
      .ctrl_wr_pulse (ctrl_wr_pulse),
      .stat_d        (stat_d)
`ifdef PAM_SEARCHER_IRQ_EN
      ,
      .irq_set       (irq_set),
      .irq           (irq)
`endif
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [31:0] m_ctrl [4];
   logic        m_aw_held, m_w_held;
   logic [5:0]  m_aw_addr;
   logic [31:0] m_w_data;
   logic [3:0]  m_w_strb;
   logic        m_bvalid;
   logic [1:0]  m_bresp;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic [3:0]  m_pulse;
   int          pulse_cnt [4];

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
      return (o & ~m) | (d & m);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_ctrl[k] = 32'h0;
      m_aw_held = 0; m_w_held = 0; m_aw_addr = '0; m_w_data = '0; m_w_strb = '0;
      m_bvalid = 0; m_bresp = 2'b00; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
      m_pulse = '0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      int idx;
      if (!rst_n) model_reset();
      chk("ctrl_q", ctrl_q, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
      chk("wr_pulse", ctrl_wr_pulse, m_pulse);
      chk("bvalid", bvalid, m_bvalid);
      if (m_bvalid) chk("bresp", bresp, m_bresp);
      chk("rvalid", rvalid, m_rvalid);
      if (m_rvalid) begin
         chk("rdata", rdata, m_rdata);
         chk("rresp", rresp, m_rresp);
      end
      for (int k = 0; k < 4; k++) if (ctrl_wr_pulse[k]) pulse_cnt[k]++;
      if (rst_n) begin
         // predict the effect of the coming rising edge
         m_pulse = '0;
         if (m_rvalid && rready) m_rvalid = 0;
         if (arvalid && arready) begin
            idx = int'(araddr) / 4;
            m_rvalid = 1;
            if (idx < 4) begin m_rdata = m_ctrl[idx]; m_rresp = 2'b00; end
            else if (idx < 6) begin m_rdata = stat_d[(idx-4)*32 +: 32]; m_rresp = 2'b00; end
            else begin m_rdata = 32'h0; m_rresp = 2'b10; end
         end
         if (m_bvalid && bready) m_bvalid = 0;
         if (awvalid && awready) begin m_aw_held = 1; m_aw_addr = awaddr; end
         if (wvalid && wready) begin m_w_held = 1; m_w_data = wdata; m_w_strb = wstrb; end
         if (m_aw_held && m_w_held) begin
            idx = int'(m_aw_addr) / 4;
            m_bvalid = 1;
            m_aw_held = 0;
            m_w_held = 0;
            if (idx < 4) begin
               m_ctrl[idx] = merge(m_ctrl[idx], m_w_data, m_w_strb);
               m_pulse[idx] = 1'b1;
               m_bresp = 2'b00;
            end else begin
`ifdef PAM_SEARCHER_IRQ_EN
               m_bresp = (idx == 6) ? 2'b00 : 2'b10;
`else
               m_bresp = 2'b10;
`endif
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_now, w_now;
      int cyc = 0;
      @(posedge clk); #1;
      bready = 1; awaddr = a; wdata = d; wstrb = s;
      wvalid = 1;
      awvalid = (w_lead == 0);
      while (!(aw_done && w_done) && cyc < 50) begin
         @(negedge clk);
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         @(posedge clk); #1;
         cyc++;
         if (aw_now) begin aw_done = 1; awvalid = 0; end
         if (w_now) begin w_done = 1; wvalid = 0; end
         if (!aw_done && cyc >= w_lead) awvalid = 1;
      end
      if (!(aw_done && w_done)) begin
         chk("wr_handshake_timeout", 1'b0, 1'b1);
         awvalid = 0; wvalid = 0; resp = 2'bxx;
         return;
      end
      @(negedge clk);
      chk("b_latency", bvalid, 1'b1);
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [5:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp);
      bit hs = 0;
      int cyc = 0;
      @(posedge clk); #1;
      araddr = a; arvalid = 1; rready = 0;
      while (!hs && cyc < 50) begin
         @(negedge clk);
         hs = arready;
         @(posedge clk); #1;
         cyc++;
      end
      arvalid = 0;
      if (!hs) begin
         chk("rd_handshake_timeout", 1'b0, 1'b1);
         d = 'x; resp = 'x;
         return;
      end
      @(negedge clk);
      chk("r_latency", rvalid, 1'b1);
      d = rdata; resp = rresp;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("r_hold_valid", rvalid, 1'b1);
         chk("r_hold_data", rdata, d);
      end
      @(posedge clk); #1;
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r;
      logic [31:0] d;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", awready, 1'b0);
      chk("rst_wready", wready, 1'b0);
      chk("rst_arready", arready, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", {rdata, rresp, bresp}, 36'h0);
      chk("rst_ctrl", ctrl_q, 128'h0);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) @(posedge clk);

      // four writes then read back
      for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
      for (int k = 0; k < 4; k++) begin
         do_write(6'(4 * k), 32'(k + 1), 4'hF, 0, r);
         chk("wr_okay", r, 2'b00);
      end
      for (int k = 0; k < 4; k++) begin
         do_read(6'(4 * k), 0, d, r);
         chk("rd_back", d, 32'(k + 1));
         chk("rd_okay", r, 2'b00);
         chk("pulse_once", 32'(pulse_cnt[k]), 32'd1);
      end

      // W leads AW by 3 cycles, partial strobe
      do_write(6'h04, 32'h11223344, 4'hF, 0, r);
      do_write(6'h04, 32'hAABBCCDD, 4'b0101, 3, r);
      chk("strb_okay", r, 2'b00);
      chk("strb_reg1", ctrl_q[63:32], 32'h11BB33DD);

      // status write and out-of-range read
      do_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, r);
      chk("stat_wr_slverr", r, 2'b10);
      chk("stat_wr_nochange", ctrl_q, {32'h4, 32'h3, 32'h11BB33DD, 32'h1});
      do_read(6'h3C, 0, d, r);
      chk("oor_rresp", r, 2'b10);
      chk("oor_rdata", d, 32'h0);
`ifndef PAM_SEARCHER_IRQ_EN
      do_read(6'h18, 0, d, r);
      chk("irq_idx_slverr", r, 2'b10);
`endif

      // status read with RREADY held off
      do_read(6'h10, 5, d, r);
      chk("stat0_rdata", d, 32'hCAFEF00D);
      chk("stat0_rresp", r, 2'b00);
      do_read(6'h14, 0, d, r);
      chk("stat1_rdata", d, 32'h5A5A0001);

      // zero-strobe write still pulses, leaves data unchanged
      do_write(6'h0C, 32'hDEADBEEF, 4'h0, 0, r);
      chk("zstrb_reg3", ctrl_q[127:96], 32'h4);

      // read and write to the same register accepted on the same edge
      @(posedge clk); #1;
      bready = 1; rready = 0;
      awaddr = 6'h08; wdata = 32'h0000ABCD; wstrb = 4'hF; araddr = 6'h08;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      chk("same_edge_ready", {awready, wready, arready}, 3'b111);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      @(negedge clk);
      chk("same_edge_old", rdata, 32'h3);
      chk("same_edge_new", ctrl_q[95:64], 32'h0000ABCD);
      @(posedge clk); #1;
      rready = 1;
      @(posedge clk); #1;
      rready = 0;

      // reset while both responses are pending
      @(posedge clk); #1;
      bready = 0; rready = 0;
      awaddr = 6'h0C; wdata = 32'h77; wstrb = 4'hF; araddr = 6'h00;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      @(negedge clk);
      chk("pre_rst_pending", {bvalid, rvalid}, 2'b11);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("async_rst_valids", {bvalid, rvalid}, 2'b00);
      chk("async_rst_ctrl", ctrl_q, 128'h0);
      @(posedge clk); #1;
      bready = 1;
      rst_n = 1;
      repeat (3) @(posedge clk);
      do_write(6'h08, 32'h5, 4'hF, 0, r);
      chk("post_rst_okay", r, 2'b00);
      chk("post_rst_reg2", ctrl_q[95:64], 32'h5);

`ifdef PAM_SEARCHER_IRQ_EN
      @(posedge clk); #1;
      irq_set = 2'b01;
      @(posedge clk); #1;
      irq_set = 2'b00;
      @(negedge clk);
      chk("irq_set", irq, 1'b1);
      @(posedge clk); #1;
      bready = 1; awaddr = 6'h18; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1; wvalid = 1; irq_set = 2'b01;
      @(negedge clk);
      chk("irq_wr_ready", {awready, wready}, 2'b11);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; irq_set = 2'b00;
      @(negedge clk);
      chk("irq_set_wins", irq, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("irq_still_set", irq, 1'b1);
      @(posedge clk); #1;
      awvalid = 1; wvalid = 1;
      @(negedge clk);
      chk("irq_clr_pre", irq, 1'b1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      @(negedge clk);
      chk("irq_cleared", irq, 1'b0);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
